// File: rtl/table_entry_fetcher_pkg.sv
// Shared types for the descriptor-table fetcher and the object buffer it feeds.
package table_entry_fetcher_pkg;

  typedef struct packed {
    logic [15:0] field_id;
    logic [7:0]  field_type;
    logic [7:0]  flags;
    logic [31:0] offset;
  } table_entry_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DRAIN,
    FETCH_DONE
  } fetch_state_t;

  localparam int ENTRY_BYTES_DEFAULT = 16;

endpackage

// File: rtl/table_entry_fetcher_resp_fifo.sv
// Small prefetch FIFO holding returned table entries until the object buffer can take them.
module fetch_resp_fifo
  import table_entry_fetcher_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  table_entry_t  push_data,
  input  logic          pop,
  output table_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  table_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/table_entry_fetcher.sv
// Walks a contiguous descriptor table in memory and streams each entry into the object buffer.
module table_entry_fetcher
  import table_entry_fetcher_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8,
  parameter int ENTRY_BYTES = ENTRY_BYTES_DEFAULT,
  parameter int PF_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_fields,
  output logic              busy,
  output logic              done,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  table_entry_t      mem_resp_data,
  output table_entry_t      entry_out,
  output logic              entry_valid,
  input  logic              buf_full
);

  localparam int CW = $clog2(PF_DEPTH) + 1;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  num_reg;
  logic [CNT_W-1:0]  req_cnt_reg;
  logic [CNT_W-1:0]  wr_cnt_reg;
  logic [CW-1:0]     outstanding_reg;
  logic              entry_valid_reg;
  table_entry_t      entry_out_reg;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  table_entry_t      fifo_head;
  logic [CW:0]       in_flight;
  logic              walking;
  logic              req_fire;
  logic              resp_accept;
  logic              write_issue;

  assign walking   = (state_reg == FETCH_REQ) || (state_reg == FETCH_DRAIN);
  assign in_flight = {1'b0, outstanding_reg} + {1'b0, fifo_count};

  // Credit check: every issued read must have a FIFO slot waiting for it.
  assign mem_req_valid = (state_reg == FETCH_REQ) && (req_cnt_reg < num_reg) &&
                         (in_flight < (CW+1)'(PF_DEPTH));
  assign mem_req_addr  = base_reg + ADDR_W'(req_cnt_reg) * ADDR_W'(ENTRY_BYTES);
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses only count when a read of this walk is still pending.
  assign resp_accept = mem_resp_valid && walking && (outstanding_reg != '0);

  // buf_full lags one write, so never issue in the cycle right after a write.
  assign write_issue = walking && !fifo_empty && !buf_full && !entry_valid_reg;

  assign busy        = (state_reg != FETCH_IDLE);
  assign done        = (state_reg == FETCH_DONE);
  assign entry_valid = entry_valid_reg;
  assign entry_out   = entry_out_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_IDLE:  if (start) state_next = (num_fields == '0) ? FETCH_DONE : FETCH_REQ;
      FETCH_REQ:   if (req_cnt_reg == num_reg) state_next = FETCH_DRAIN;
      FETCH_DRAIN: if (wr_cnt_reg == num_reg) state_next = FETCH_DONE;
      FETCH_DONE:  state_next = FETCH_IDLE;
      default:     state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= FETCH_IDLE;
      base_reg        <= '0;
      num_reg         <= '0;
      req_cnt_reg     <= '0;
      wr_cnt_reg      <= '0;
      outstanding_reg <= '0;
      entry_valid_reg <= 1'b0;
      entry_out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH_IDLE && start) begin
        base_reg    <= base_addr;
        num_reg     <= num_fields;
        req_cnt_reg <= '0;
        wr_cnt_reg  <= '0;
      end else begin
        if (req_fire)    req_cnt_reg <= req_cnt_reg + CNT_W'(1);
        if (write_issue) wr_cnt_reg  <= wr_cnt_reg + CNT_W'(1);
      end
      case ({req_fire, resp_accept})
        2'b10:   outstanding_reg <= outstanding_reg + CW'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CW'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
      entry_valid_reg <= write_issue;
      if (write_issue) entry_out_reg <= fifo_head;
    end
  end

  fetch_resp_fifo #(
    .DEPTH (PF_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (resp_accept),
    .push_data (mem_resp_data),
    .pop       (write_issue),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_table_entry_fetcher.sv
// Randomized bench: memory/buffer models drive the fetcher; expected entries come from the table contents.
`timescale 1ns/1ps
module tb_table_entry_fetcher;
  import table_entry_fetcher_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int CNT_W       = 8;
  localparam int ENTRY_BYTES = 16;
  localparam int PF_DEPTH    = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [7:0]   num_fields = '0;
  logic         busy, done, mem_req_valid, entry_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  table_entry_t mem_resp_data = '0;
  table_entry_t entry_out;
  logic         buf_full = 1'b0;

  table_entry_fetcher #(
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .ENTRY_BYTES (ENTRY_BYTES),
    .PF_DEPTH    (PF_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .num_fields     (num_fields),
    .busy           (busy),
    .done           (done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .entry_out      (entry_out),
    .entry_valid    (entry_valid),
    .buf_full       (buf_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Table contents in memory: a fixed scramble of the entry address.
  function automatic table_entry_t mem_entry(input logic [31:0] addr);
    logic [63:0] raw;
    raw = {addr ^ 32'hA5A5_0F0F, (~addr) + 32'd7};
    return table_entry_t'(raw);
  endfunction

  function automatic logic [31:0] entry_addr(input logic [31:0] base, input int idx);
    return base + 32'(idx) * 32'(ENTRY_BYTES);
  endfunction

  typedef struct {
    longint      due;
    logic [31:0] addr;
  } pend_t;

  // Per-walk configuration and observation log
  int           lat = 1;
  bit           rnd_ready = 0, rnd_full = 0;
  int           full_at = -1, full_len = 0, stall_at = -1, stall_len = 0;
  longint       t0 = 0;
  longint       cyc = 0;
  table_entry_t got_q[$];
  logic [31:0]  addr_q[$];
  pend_t        pend_q[$];
  int           hs_cnt, done_cnt, req_seen, b2b, full_viol, unstable, max_inflight;
  int           first_entry_cyc, done_cyc;
  logic         busy_at1;
  bit           prev_stalled = 0, prev_ev = 0, prev_full = 0;
  logic [31:0]  prev_addr = '0;

  // Memory and object-buffer model: observe on the falling edge, then drive the next cycle's inputs.
  initial begin
    longint wc;
    bit     rdy, full_n;
    pend_t  p;
    forever begin
      @(negedge clk);
      cyc++;
      wc = ($time - t0) / 10;
      if (prev_stalled && (!mem_req_valid || mem_req_addr !== prev_addr)) unstable++;
      if (entry_valid) begin
        got_q.push_back(entry_out);
        if (prev_ev) b2b++;
        if (prev_full) full_viol++;
        if (first_entry_cyc < 0) first_entry_cyc = int'(wc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = int'(wc);
      end
      if (mem_req_valid) req_seen++;
      if (wc == 1) busy_at1 = busy;
      if (hs_cnt - got_q.size() > max_inflight) max_inflight = hs_cnt - got_q.size();

      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_at >= 0 && wc >= stall_at && wc < stall_at + stall_len) rdy = 1'b0;
      full_n = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (full_at >= 0 && wc >= full_at && wc < full_at + full_len) full_n = 1'b1;
      mem_req_ready = rdy;
      buf_full      = full_n;

      if (mem_req_valid && rdy) begin
        addr_q.push_back(mem_req_addr);
        p.due  = cyc + lat;
        p.addr = mem_req_addr;
        pend_q.push_back(p);
        hs_cnt++;
      end
      prev_stalled = mem_req_valid && !rdy;
      prev_addr    = mem_req_addr;

      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_entry(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = table_entry_t'({$urandom, $urandom});
      end
      prev_ev   = entry_valid;
      prev_full = full_n;
    end
  end

  task automatic start_walk(input logic [31:0] base, input int n, input int lat_i,
                            input bit rr, input bit rf, input int fa, input int fl,
                            input int sa, input int sl);
    @(posedge clk);
    #1;
    lat = lat_i; rnd_ready = rr; rnd_full = rf;
    full_at = fa; full_len = fl; stall_at = sa; stall_len = sl;
    got_q.delete();
    addr_q.delete();
    hs_cnt = 0; done_cnt = 0; req_seen = 0; b2b = 0; full_viol = 0; unstable = 0;
    max_inflight = 0; first_entry_cyc = -1; done_cyc = -1; busy_at1 = 1'b0;
    prev_stalled = 0; prev_ev = 0; prev_full = 0;
    base_addr  = base;
    num_fields = 8'(n);
    start      = 1'b1;
    t0         = $time;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_walk(input string name, input logic [31:0] base, input int n);
    int budget;
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    #1;
    check_eq({name, "_done_pulses"}, done_cnt, 1);
    check_eq({name, "_entry_count"}, got_q.size(), n);
    check_eq({name, "_req_count"}, addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < addr_q.size()) check_eq($sformatf("%s_addr%0d", name, i), addr_q[i], entry_addr(base, i));
      if (i < got_q.size())  check_eq($sformatf("%s_entry%0d", name, i), got_q[i], mem_entry(entry_addr(base, i)));
    end
    check_eq({name, "_back_to_back"}, b2b, 0);
    check_eq({name, "_write_while_full"}, full_viol, 0);
    check_eq({name, "_addr_unstable"}, unstable, 0);
    check_eq({name, "_credit_ok"}, max_inflight <= PF_DEPTH, 1);
    check_eq({name, "_busy_after"}, busy, 0);
    $display("walk %s base=0x%08h n=%0d entries=%0d reqs=%0d done_cyc=%0d max_inflight=%0d",
             name, base, n, got_q.size(), addr_q.size(), done_cyc, max_inflight);
  endtask

  task automatic check_outputs_zero(input string name);
    check_eq({name, "_busy"}, busy, 0);
    check_eq({name, "_done"}, done, 0);
    check_eq({name, "_req_valid"}, mem_req_valid, 0);
    check_eq({name, "_req_addr"}, mem_req_addr, 0);
    check_eq({name, "_entry_valid"}, entry_valid, 0);
    check_eq({name, "_entry_out"}, entry_out, 0);
  endtask

  initial begin
    logic [31:0] rb;
    int          rn, budget;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic walk with an always-ready, one-cycle memory
    start_walk(32'h0000_1000, 3, 1, 0, 0, -1, 0, -1, 0);
    finish_walk("basic", 32'h0000_1000, 3);
    check_eq("basic_first_entry_cyc", first_entry_cyc, 4);
    check_eq("basic_busy_at1", busy_at1, 1);

    // Empty table
    start_walk(32'h0000_3000, 0, 1, 0, 0, -1, 0, -1, 0);
    finish_walk("empty", 32'h0000_3000, 0);
    check_eq("empty_req_valid_cycles", req_seen, 0);
    check_eq("empty_done_cyc", done_cyc, 1);

    // Buffer full for 10 cycles mid-walk
    start_walk(32'h0001_0000, 8, 1, 0, 0, 5, 10, -1, 0);
    finish_walk("full10", 32'h0001_0000, 8);

    // Request channel stalled for 5 cycles
    start_walk(32'h0000_2000, 4, 1, 0, 0, -1, 0, 2, 5);
    finish_walk("stall5", 32'h0000_2000, 4);
    check_eq("stall5_req_valid_held", req_seen >= 9, 1);

    // Address wraps past the top of memory
    start_walk(32'hFFFF_FFF0, 2, 1, 0, 0, -1, 0, -1, 0);
    finish_walk("wrap", 32'hFFFF_FFF0, 2);

    // Random tables, memory latency and backpressure
    for (int k = 0; k < 8; k++) begin
      rb = $urandom;
      rn = $urandom_range(1, 20);
      start_walk(rb, rn, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1, 0, -1, 0);
      finish_walk($sformatf("rand%0d", k), rb, rn);
    end

    // Reset mid-walk with reads still outstanding, then a fresh one-entry table
    start_walk(32'h0000_4000, 6, 3, 0, 0, -1, 0, -1, 0);
    budget = 0;
    while (pend_q.size() != 2 && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_eq("midrst_outstanding", pend_q.size(), 2);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    budget = 0;
    while (pend_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    start_walk(32'h0000_8000, 1, 1, 0, 0, -1, 0, -1, 0);
    finish_walk("after_rst", 32'h0000_8000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
